// File: rtl/demux_deser_pkg.sv
// Shared definitions for demux_deser: lane-count helper and architecture selectors.
package demux_deser_pkg;

  localparam string ARCH_BEHAVIORAL = "BEHAVIORAL";
  localparam string ARCH_VIRTEX5    = "VIRTEX5";
  localparam string ARCH_VIRTEX6    = "VIRTEX6";

  function automatic int unsigned lanes(input int unsigned sel);
    return 32'd1 << sel;
  endfunction

endpackage

// File: rtl/demux_deser.sv
// Sequential lane demux: narrow words accepted one per beat are packed into a
// wide frame (lane 0 in the LSBs) and handed downstream with valid/ready.
module demux_deser
  import demux_deser_pkg::*;
#(
  parameter string BLOCK_NAME   = "demux_deser",
  parameter int    X            = 0,
  parameter int    Y            = 0,
  parameter int    DX           = 0,
  parameter int    DY           = 0,
  parameter string ARCHITECTURE = "BEHAVIORAL",
  parameter int    SELECT_LINES = 4,
  parameter int    DATA_WIDTH   = 1
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          sync,
  input  logic [DATA_WIDTH-1:0]                         data_in,
  input  logic                                          data_in_valid,
  output logic                                          data_in_ready,
  output logic [DATA_WIDTH*lanes(SELECT_LINES)-1:0]     data_out,
  output logic                                          data_out_valid,
  input  logic                                          data_out_ready,
  output logic [SELECT_LINES-1:0]                       lane,
  output logic                                          sync_err
);

  localparam int unsigned LANES = lanes(SELECT_LINES);
  localparam int unsigned FW    = DATA_WIDTH * LANES;

  if (SELECT_LINES < 1 || SELECT_LINES > 8) begin : g_bad_sel
    $error("demux_deser: SELECT_LINES must be in 1..8");
  end

  if (BLOCK_NAME == "" || X < 0 || Y < 0 || DX < 0 || DY < 0) begin : g_bad_place
    $error("demux_deser: invalid block name or placement");
  end

  if (ARCHITECTURE == ARCH_BEHAVIORAL) begin : g_behavioral
    localparam logic [SELECT_LINES-1:0] LAST = SELECT_LINES'(LANES - 1);

    logic                    rdy_en;
    logic [SELECT_LINES-1:0] lane_q;
    logic [FW-1:0]           asm_q;
    logic [FW-1:0]           out_q;
    logic                    out_valid_q;
    logic                    err_q;

    logic          at_last;
    logic          stall;
    logic          ready;
    logic          accept;
    logic          complete;
    logic [FW-1:0] frame;

    // Only the final word can stall: earlier lanes land in asm_q, which acts
    // as the second buffer behind a frame still waiting in out_q.
    always_comb begin
      at_last  = (lane_q == LAST);
      stall    = at_last & out_valid_q & ~data_out_ready;
      ready    = rdy_en & ~stall;
      accept   = data_in_valid & ready;
      complete = accept & ~sync & at_last;
      frame    = asm_q;
      frame[DATA_WIDTH*(LANES-1) +: DATA_WIDTH] = data_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdy_en      <= 1'b0;
        lane_q      <= '0;
        asm_q       <= '0;
        out_q       <= '0;
        out_valid_q <= 1'b0;
        err_q       <= 1'b0;
      end else begin
        rdy_en <= 1'b1;
        if (accept) begin
          if (sync) begin
            asm_q[DATA_WIDTH-1:0] <= data_in;
            lane_q                <= SELECT_LINES'(1);
            if (lane_q != '0) err_q <= 1'b1;
          end else begin
            asm_q[DATA_WIDTH*int'(lane_q) +: DATA_WIDTH] <= data_in;
            lane_q <= lane_q + 1'b1;
          end
        end
        if (complete) begin
          out_q       <= frame;
          out_valid_q <= 1'b1;
        end else if (out_valid_q && data_out_ready) begin
          out_valid_q <= 1'b0;
        end
      end
    end

    assign data_in_ready  = ready;
    assign data_out       = out_q;
    assign data_out_valid = out_valid_q;
    assign lane           = lane_q;
    assign sync_err       = err_q;
  end else begin : g_vendor
    // Vendor-primitive variants are placeholders; outputs are tied off.
    assign data_in_ready  = 1'b0;
    assign data_out       = '0;
    assign data_out_valid = 1'b0;
    assign lane           = '0;
    assign sync_err       = 1'b0;
  end

endmodule

// File: tb/tb_demux_deser.sv
// Bench for demux_deser: two configurations checked against a word-queue model.
module tb_demux_deser;

  logic clk;
  logic rst_n;

  logic        a_sync, a_valid, a_oready, a_rdy, a_ov, a_serr;
  logic [7:0]  a_data;
  logic [31:0] a_dout;
  logic [1:0]  a_lane;

  logic        b_sync, b_valid, b_oready, b_rdy, b_ov, b_serr;
  logic [0:0]  b_data;
  logic [15:0] b_dout;
  logic [3:0]  b_lane;

  demux_deser #(.SELECT_LINES(2), .DATA_WIDTH(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .sync(a_sync), .data_in(a_data),
    .data_in_valid(a_valid), .data_in_ready(a_rdy), .data_out(a_dout),
    .data_out_valid(a_ov), .data_out_ready(a_oready), .lane(a_lane),
    .sync_err(a_serr));

  demux_deser #(.SELECT_LINES(4), .DATA_WIDTH(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .sync(b_sync), .data_in(b_data),
    .data_in_valid(b_valid), .data_in_ready(b_rdy), .data_out(b_dout),
    .data_out_valid(b_ov), .data_out_ready(b_oready), .lane(b_lane),
    .sync_err(b_serr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: words of the frame in progress, words of completed frames awaiting
  // delivery, frames awaiting delivery, sticky sync error.
  int q_part[$];
  int q_done[$];
  int pend;
  bit m_err;
  int frames_out;

  // Last sampled DUT values.
  logic        s_rdy, s_ov, s_serr;
  logic [31:0] s_dout;
  logic [7:0]  s_lane;

  function automatic void model_reset();
    q_part.delete();
    q_done.delete();
    pend  = 0;
    m_err = 0;
  endfunction

  task automatic sample(input int d);
    if (d == 0) begin
      s_rdy = a_rdy; s_ov = a_ov; s_serr = a_serr;
      s_dout = a_dout; s_lane = {6'b0, a_lane};
    end else begin
      s_rdy = b_rdy; s_ov = b_ov; s_serr = b_serr;
      s_dout = {16'b0, b_dout}; s_lane = {4'b0, b_lane};
    end
  endtask

  task automatic cycle(input int d, input bit v, input bit s, input int w,
                       input bit ordy, output bit acc);
    int L, DW, word;
    bit exp_ov, exp_rdy, mism;
    logic [31:0] mask, exp_frame;
    L    = (d == 0) ? 4 : 16;
    DW   = (d == 0) ? 8 : 1;
    mask = (d == 0) ? 32'hFF : 32'h1;
    word = w & int'(mask);
    @(negedge clk);
    if (d == 0) begin
      a_valid = v; a_sync = s; a_data = word[7:0]; a_oready = ordy;
    end else begin
      b_valid = v; b_sync = s; b_data = word[0]; b_oready = ordy;
    end
    #1;
    sample(d);
    exp_ov  = (pend > 0);
    exp_rdy = !(q_part.size() == L - 1 && exp_ov && !ordy);
    tests++;
    if ({s_rdy, s_ov, s_serr} !== {exp_rdy, exp_ov, m_err} || s_lane !== 8'(q_part.size())) begin
      fails++;
      $display("FAIL status d%0d got rdy=%b ov=%b err=%b lane=%0d, want rdy=%b ov=%b err=%b lane=%0d",
               d, s_rdy, s_ov, s_serr, s_lane, exp_rdy, exp_ov, m_err, q_part.size());
    end
    if (exp_ov) begin
      mism = (q_done.size() < L);
      exp_frame = '0;
      for (int j = 0; j < L && j < q_done.size(); j++) begin
        exp_frame = exp_frame | (32'(q_done[j]) << (j * DW));
        if (((s_dout >> (j * DW)) & mask) !== 32'(q_done[j])) mism = 1;
      end
      tests++;
      if (mism) begin
        fails++;
        $display("FAIL frame d%0d got %h want %h", d, s_dout, exp_frame);
      end
      if (ordy) begin
        for (int j = 0; j < L && q_done.size() > 0; j++) void'(q_done.pop_front());
        pend--;
        frames_out++;
      end
    end
    acc = v && exp_rdy;
    if (acc) begin
      if (s) begin
        if (q_part.size() != 0) m_err = 1;
        q_part.delete();
        q_part.push_back(word);
      end else begin
        q_part.push_back(word);
        if (q_part.size() == L) begin
          foreach (q_part[k]) q_done.push_back(q_part[k]);
          q_part.delete();
          pend++;
        end
      end
    end
  endtask

  task automatic send(input int d, input int w, input bit s, input bit ordy);
    bit acc;
    int n;
    n = 0;
    do begin
      cycle(d, 1'b1, s, w, ordy, acc);
      n++;
    end while (!acc && n < 50);
    if (!acc) begin
      tests++; fails++;
      $display("FAIL send_timeout d%0d word %h not accepted, want accepted", d, w);
    end
  endtask

  task automatic idle(input int d, input bit ordy);
    bit acc;
    cycle(d, 1'b0, 1'b0, 0, ordy, acc);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    tests++;
    if (a_rdy !== 1'b0 || b_rdy !== 1'b0) begin
      fails++;
      $display("FAIL ready_before_edge got a=%b b=%b want 0 0", a_rdy, b_rdy);
    end
  endtask

  task automatic do_reset();
    a_valid = 0; a_sync = 0; a_data = '0; a_oready = 1;
    b_valid = 0; b_sync = 0; b_data = '0; b_oready = 1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    release_reset();
  endtask

  task automatic test_reset();
    a_valid = 0; a_sync = 0; a_data = '0; a_oready = 1;
    b_valid = 0; b_sync = 0; b_data = '0; b_oready = 1;
    rst_n = 1'b0;
    #3;
    tests++;
    if ({a_ov, a_serr, a_rdy, a_lane, a_dout} !== '0 || {b_ov, b_serr, b_rdy, b_lane, b_dout} !== '0) begin
      fails++;
      $display("FAIL reset_state got a:%b%b%b %0d %h b:%b%b%b %0d %h want all 0",
               a_ov, a_serr, a_rdy, a_lane, a_dout, b_ov, b_serr, b_rdy, b_lane, b_dout);
    end
    repeat (2) @(negedge clk);
    release_reset();
    idle(0, 1'b1);
  endtask

  task automatic test_single_frame();
    do_reset();
    send(0, 'h11, 0, 1); send(0, 'h22, 0, 1);
    send(0, 'h33, 0, 1); send(0, 'h44, 0, 1);
    idle(0, 1'b1);
    tests++;
    if (s_ov !== 1'b1 || s_dout !== 32'h44332211) begin
      fails++;
      $display("FAIL single_frame got ov=%b %h want 1 44332211", s_ov, s_dout);
    end
    idle(0, 1'b1);
    tests++;
    if (s_ov !== 1'b0) begin
      fails++;
      $display("FAIL single_pulse got ov=%b want 0", s_ov);
    end
  endtask

  task automatic test_back_to_back();
    bit acc;
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      cycle(0, 1'b1, 1'b0, i, 1'b1, acc);
      tests++;
      if (acc !== 1'b1 || s_rdy !== 1'b1) begin
        fails++;
        $display("FAIL b2b_ready word %0d got rdy=%b want 1", i, s_rdy);
      end
    end
    idle(0, 1'b1);
    tests++;
    if (s_ov !== 1'b1 || s_dout !== 32'h08070605) begin
      fails++;
      $display("FAIL b2b_frame2 got ov=%b %h want 1 08070605", s_ov, s_dout);
    end
    idle(0, 1'b1);
  endtask

  task automatic test_backpressure();
    bit acc;
    do_reset();
    for (int i = 1; i <= 4; i++) send(0, i, 0, 1);
    for (int i = 5; i <= 7; i++) begin
      cycle(0, 1'b1, 1'b0, i, 1'b0, acc);
      tests++;
      if (acc !== 1'b1) begin
        fails++;
        $display("FAIL bp_accept word %0d got rdy=%b want 1", i, s_rdy);
      end
    end
    repeat (3) begin
      cycle(0, 1'b1, 1'b0, 8, 1'b0, acc);
      tests++;
      if (s_rdy !== 1'b0 || s_dout !== 32'h04030201 || s_lane !== 8'd3) begin
        fails++;
        $display("FAIL bp_stall got rdy=%b %h lane=%0d want 0 04030201 3", s_rdy, s_dout, s_lane);
      end
    end
    cycle(0, 1'b1, 1'b0, 8, 1'b1, acc);
    tests++;
    if (acc !== 1'b1) begin
      fails++;
      $display("FAIL bp_release got rdy=%b want 1", s_rdy);
    end
    idle(0, 1'b1);
    tests++;
    if (s_ov !== 1'b1 || s_dout !== 32'h08070605) begin
      fails++;
      $display("FAIL bp_frame2 got ov=%b %h want 1 08070605", s_ov, s_dout);
    end
    idle(0, 1'b1);
  endtask

  task automatic test_sync();
    bit acc;
    do_reset();
    send(0, 'hA1, 0, 1); send(0, 'hA2, 0, 1);
    cycle(0, 1'b0, 1'b1, 'hEE, 1'b1, acc);
    send(0, 'hB0, 1, 1);
    send(0, 'hB1, 0, 1); send(0, 'hB2, 0, 1); send(0, 'hB3, 0, 1);
    idle(0, 1'b1);
    tests++;
    if (s_serr !== 1'b1 || s_ov !== 1'b1 || s_dout !== 32'hB3B2B1B0) begin
      fails++;
      $display("FAIL sync_realign got err=%b ov=%b %h want 1 1 B3B2B1B0", s_serr, s_ov, s_dout);
    end
    send(0, 'hC0, 0, 1); send(0, 'hC1, 0, 1); send(0, 'hC2, 0, 1);
    send(0, 'hD0, 1, 1);
    send(0, 'hD1, 0, 1); send(0, 'hD2, 0, 1); send(0, 'hD3, 0, 1);
    idle(0, 1'b1);
    tests++;
    if (s_ov !== 1'b1 || s_dout !== 32'hD3D2D1D0) begin
      fails++;
      $display("FAIL sync_last_lane got ov=%b %h want 1 D3D2D1D0", s_ov, s_dout);
    end
    idle(0, 1'b1);
  endtask

  task automatic test_async_reset();
    bit acc;
    do_reset();
    send(0, 'h55, 0, 1); send(0, 'h66, 0, 1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (a_lane !== 2'd0 || a_ov !== 1'b0 || a_dout !== '0) begin
      fails++;
      $display("FAIL async_mid_frame got lane=%0d ov=%b %h want 0 0 0", a_lane, a_ov, a_dout);
    end
    release_reset();
    for (int i = 1; i <= 4; i++) send(0, 'h10 + i, 0, 1);
    for (int i = 5; i <= 7; i++) begin
      cycle(0, 1'b1, 1'b0, 'h10 + i, 1'b0, acc);
    end
    cycle(0, 1'b1, 1'b0, 'h18, 1'b0, acc);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (a_lane !== 2'd0 || a_ov !== 1'b0 || a_dout !== '0 || a_rdy !== 1'b0) begin
      fails++;
      $display("FAIL async_mid_stall got lane=%0d ov=%b %h rdy=%b want 0 0 0 0", a_lane, a_ov, a_dout, a_rdy);
    end
    a_valid = 0; a_oready = 1;
    release_reset();
    idle(0, 1'b1);
    tests++;
    if (s_ov !== 1'b0) begin
      fails++;
      $display("FAIL async_no_output got ov=%b want 0", s_ov);
    end
    for (int i = 1; i <= 4; i++) send(0, 'hC0 + i, 0, 1);
    idle(0, 1'b1);
    tests++;
    if (s_ov !== 1'b1 || s_dout !== 32'hC4C3C2C1) begin
      fails++;
      $display("FAIL async_fresh_frame got ov=%b %h want 1 C4C3C2C1", s_ov, s_dout);
    end
    idle(0, 1'b1);
  endtask

  task automatic test_random();
    bit acc;
    int n;
    do_reset();
    frames_out = 0;
    n = 0;
    while (frames_out < 1000 && n < 70000) begin
      cycle(1, ($urandom_range(0, 3) != 0), 1'b0, int'($urandom), ($urandom_range(0, 3) != 0), acc);
      n++;
    end
    n = 0;
    while (pend > 0 && n < 20) begin
      idle(1, 1'b1);
      n++;
    end
    tests++;
    if (frames_out < 1000 || pend != 0 || q_done.size() != 0) begin
      fails++;
      $display("FAIL random_drain got frames=%0d pending=%0d words=%0d want >=1000 0 0",
               frames_out, pend, q_done.size());
    end
  endtask

  initial begin
    frames_out = 0;
    model_reset();
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_backpressure();
    test_sync();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
